// File: rtl/imm_pkg.sv
// Shared opcodes, immediate format codes and skid-buffer states for the
// immediate-generation stage.
package imm_pkg;

    localparam logic [6:0] LUI       = 7'b0110111;
    localparam logic [6:0] AUIPC     = 7'b0010111;
    localparam logic [6:0] JAL       = 7'b1101111;
    localparam logic [6:0] JALR      = 7'b1100111;
    localparam logic [6:0] BRANCH    = 7'b1100011;
    localparam logic [6:0] LOAD      = 7'b0000011;
    localparam logic [6:0] STORE     = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP        = 7'b0110011;
    localparam logic [6:0] OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OP_32     = 7'b0111011;

    typedef enum logic [2:0] {
        R    = 3'd0,
        I    = 3'd1,
        S    = 3'd2,
        B    = 3'd3,
        U    = 3'd4,
        J    = 3'd5,
        SH   = 3'd6,
        NONE = 3'd7
    } imm_fmt_e;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skid_state_e;

endpackage

// File: rtl/imm_gen_stage_if.sv
// Valid/ready bus between the front end, the immediate stage and its consumer.
interface imm_gen_stage_if #(
    parameter int XLEN  = 32,
    parameter int LANES = 1
);
    logic                    in_valid;
    logic                    in_ready;
    logic [32*LANES-1:0]     in_instr;
    logic                    out_valid;
    logic                    out_ready;
    logic [XLEN*LANES-1:0]   out_imm;
    logic [3*LANES-1:0]      out_fmt;
    logic [LANES-1:0]        out_illegal;
    logic [32*LANES-1:0]     out_instr;

    modport master (
        output in_valid, in_instr, out_ready,
        input  in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr
    );

    modport slave (
        input  in_valid, in_instr, out_ready,
        output in_ready, out_valid, out_imm, out_fmt, out_illegal, out_instr
    );
endinterface

// File: rtl/imm_decode_lane.sv
// Combinational immediate, format and legality decode for one instruction.
module imm_decode_lane
    import imm_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [31:0]      instr,
    output logic [XLEN-1:0]  imm,
    output imm_fmt_e         fmt,
    output logic             illegal
);

    function automatic logic [XLEN-1:0] sext32(input logic [31:0] v);
        sext32 = XLEN'($signed(v));
    endfunction

    logic [2:0] funct3_s;
    logic       is_shift_s;

    assign funct3_s   = instr[14:12];
    assign is_shift_s = (funct3_s == 3'b001) || (funct3_s == 3'b101);

    // Opcode decode; RV64 shifts take a 6-bit shamt, W-forms keep 5 bits.
    always_comb begin
        imm     = {XLEN{1'b0}};
        fmt     = NONE;
        illegal = 1'b0;
        case (instr[6:0])
            LUI, AUIPC: begin
                fmt = U;
                imm = sext32({instr[31:12], 12'h000});
            end
            JAL: begin
                fmt = J;
                imm = sext32({{11{instr[31]}}, instr[31], instr[19:12],
                              instr[20], instr[30:21], 1'b0});
            end
            BRANCH: begin
                fmt = B;
                imm = sext32({{19{instr[31]}}, instr[31], instr[7],
                              instr[30:25], instr[11:8], 1'b0});
            end
            STORE: begin
                fmt = S;
                imm = sext32({{20{instr[31]}}, instr[31:25], instr[11:7]});
            end
            JALR, LOAD: begin
                fmt = I;
                imm = sext32({{20{instr[31]}}, instr[31:20]});
            end
            OP_IMM: begin
                if (is_shift_s) begin
                    fmt = SH;
                    if (XLEN == 64) begin
                        imm = XLEN'(instr[25:20]);
                    end else begin
                        imm = XLEN'(instr[24:20]);
                    end
                end else begin
                    fmt = I;
                    imm = sext32({{20{instr[31]}}, instr[31:20]});
                end
            end
            OP: begin
                fmt = R;
            end
            OP_IMM_32: begin
                if (XLEN != 64) begin
                    illegal = 1'b1;
                end else if (is_shift_s) begin
                    fmt = SH;
                    imm = XLEN'(instr[24:20]);
                end else begin
                    fmt = I;
                    imm = sext32({{20{instr[31]}}, instr[31:20]});
                end
            end
            OP_32: begin
                if (XLEN == 64) begin
                    fmt = R;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/imm_gen_stage.sv
// Registered multi-lane immediate stage: per-lane decode feeding a 2-entry
// skid buffer (or a single output register when SKID = 0).
module imm_gen_stage
    import imm_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int LANES = 1,
    parameter int SKID  = 1
) (
    input  logic            clk,
    input  logic            reset,
    imm_gen_stage_if.slave  bus
);

    localparam int MW = XLEN * LANES;
    localparam int FW = 3 * LANES;
    localparam int LW = LANES;
    localparam int IW = 32 * LANES;
    localparam int BW = IW + LW + FW + MW;

    logic [MW-1:0] dec_imm_s;
    logic [FW-1:0] dec_fmt_s;
    logic [LW-1:0] dec_ill_s;
    logic [BW-1:0] dec_beat_s;
    logic [BW-1:0] main_r;
    logic [BW-1:0] skid_r;
    skid_state_e   state_r;
    logic          push_s;
    logic          pop_s;
    logic          out_valid_s;
    logic          in_ready_s;

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        imm_decode_lane #(.XLEN(XLEN)) u_lane (
            .instr   (bus.in_instr[32*g +: 32]),
            .imm     (dec_imm_s[XLEN*g +: XLEN]),
            .fmt     (dec_fmt_s[3*g +: 3]),
            .illegal (dec_ill_s[g])
        );
    end

    assign dec_beat_s  = {bus.in_instr, dec_ill_s, dec_fmt_s, dec_imm_s};
    assign out_valid_s = (state_r != EMPTY);

    // Acceptance: with the skid buffer, readiness comes only from the state register.
    always_comb begin
        if (reset) begin
            in_ready_s = 1'b0;
        end else if (SKID == 1) begin
            in_ready_s = (state_r != FULL);
        end else begin
            in_ready_s = bus.out_ready | ~out_valid_s;
        end
    end

    assign push_s = bus.in_valid & in_ready_s;
    assign pop_s  = out_valid_s & bus.out_ready;

    // Buffer FSM; main_r always holds the oldest beat, skid_r the next one.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r <= EMPTY;
            main_r  <= {BW{1'b0}};
            skid_r  <= {BW{1'b0}};
        end else if (SKID == 1) begin
            case (state_r)
                EMPTY: begin
                    if (push_s) begin
                        main_r  <= dec_beat_s;
                        state_r <= ONE;
                    end
                end
                ONE: begin
                    if (push_s && pop_s) begin
                        main_r <= dec_beat_s;
                    end else if (push_s) begin
                        skid_r  <= dec_beat_s;
                        state_r <= FULL;
                    end else if (pop_s) begin
                        state_r <= EMPTY;
                    end
                end
                FULL: begin
                    if (pop_s) begin
                        main_r  <= skid_r;
                        state_r <= ONE;
                    end
                end
                default: begin
                    state_r <= EMPTY;
                end
            endcase
        end else begin
            if (push_s) begin
                main_r  <= dec_beat_s;
                state_r <= ONE;
            end else if (pop_s) begin
                state_r <= EMPTY;
            end
        end
    end

    assign bus.in_ready    = in_ready_s;
    assign bus.out_valid   = out_valid_s;
    assign bus.out_imm     = main_r[0 +: MW];
    assign bus.out_fmt     = main_r[MW +: FW];
    assign bus.out_illegal = main_r[MW+FW +: LW];
    assign bus.out_instr   = main_r[MW+FW+LW +: IW];

endmodule

// File: tb/tb_imm_gen_stage.sv
// Directed bench for imm_gen_stage: RV32 single lane, RV32 dual lane, RV64.
module tb_imm_gen_stage;

    logic clk = 1'b0;
    logic reset;
    int   n_cmp = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    imm_gen_stage_if #(.XLEN(32), .LANES(1)) b32 ();
    imm_gen_stage_if #(.XLEN(32), .LANES(2)) b2 ();
    imm_gen_stage_if #(.XLEN(64), .LANES(1)) b64 ();

    imm_gen_stage #(.XLEN(32), .LANES(1), .SKID(1)) u32 (.clk(clk), .reset(reset), .bus(b32));
    imm_gen_stage #(.XLEN(32), .LANES(2), .SKID(1)) u2  (.clk(clk), .reset(reset), .bus(b2));
    imm_gen_stage #(.XLEN(64), .LANES(1), .SKID(1)) u64 (.clk(clk), .reset(reset), .bus(b64));

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [31:0] vin  [10];
    logic [31:0] vimm [10];
    logic [2:0]  vfmt [10];
    logic        vill [10];

    initial begin
        reset = 1'b1;
        b32.in_valid = 1'b0; b32.in_instr = 32'h0; b32.out_ready = 1'b1;
        b2.in_valid  = 1'b0; b2.in_instr  = 64'h0; b2.out_ready  = 1'b1;
        b64.in_valid = 1'b0; b64.in_instr = 32'h0; b64.out_ready = 1'b1;

        vin[0] = 32'hFFDFF0EF; vimm[0] = 32'hFFFFFFFC; vfmt[0] = 3'd5; vill[0] = 1'b0;
        vin[1] = 32'hFE000CE3; vimm[1] = 32'hFFFFFFF8; vfmt[1] = 3'd3; vill[1] = 1'b0;
        vin[2] = 32'hFE21AE23; vimm[2] = 32'hFFFFFFFC; vfmt[2] = 3'd2; vill[2] = 1'b0;
        vin[3] = 32'h123450B7; vimm[3] = 32'h12345000; vfmt[3] = 3'd4; vill[3] = 1'b0;
        vin[4] = 32'h4050D093; vimm[4] = 32'h00000005; vfmt[4] = 3'd6; vill[4] = 1'b0;
        vin[5] = 32'h0000007F; vimm[5] = 32'h00000000; vfmt[5] = 3'd7; vill[5] = 1'b1;
        vin[6] = 32'hFFC08067; vimm[6] = 32'hFFFFFFFC; vfmt[6] = 3'd1; vill[6] = 1'b0;
        vin[7] = 32'h00208033; vimm[7] = 32'h00000000; vfmt[7] = 3'd0; vill[7] = 1'b0;
        vin[8] = 32'h00001017; vimm[8] = 32'h00001000; vfmt[8] = 3'd4; vill[8] = 1'b0;
        vin[9] = 32'h0000001B; vimm[9] = 32'h00000000; vfmt[9] = 3'd7; vill[9] = 1'b1;

        tick();
        tick();
        chk("rst_in_ready", {63'h0, b32.in_ready}, 64'h0);
        chk("rst_out_valid", {63'h0, b32.out_valid}, 64'h0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", {63'h0, b32.in_ready}, 64'h1);
        chk("post_rst_imm", {32'h0, b32.out_imm}, 64'h0);
        chk("post_rst_instr", {32'h0, b32.out_instr}, 64'h0);

        // RV32 single-lane decode, full throughput
        for (int k = 0; k < 10; k++) begin
            b32.in_valid = 1'b1;
            b32.in_instr = vin[k];
            tick();
            chk($sformatf("v%0d_valid", k), {63'h0, b32.out_valid}, 64'h1);
            chk($sformatf("v%0d_imm", k), {32'h0, b32.out_imm}, {32'h0, vimm[k]});
            chk($sformatf("v%0d_fmt", k), {61'h0, b32.out_fmt}, {61'h0, vfmt[k]});
            chk($sformatf("v%0d_ill", k), {63'h0, b32.out_illegal}, {63'h0, vill[k]});
            chk($sformatf("v%0d_instr", k), {32'h0, b32.out_instr}, {32'h0, vin[k]});
        end
        b32.in_valid = 1'b0;
        tick();
        chk("drain_valid", {63'h0, b32.out_valid}, 64'h0);

        // Backpressure: A..D = addi imm 1..4
        b32.out_ready = 1'b0;
        b32.in_valid  = 1'b1;
        b32.in_instr  = 32'h00100093;
        chk("bp_ready_empty", {63'h0, b32.in_ready}, 64'h1);
        tick();
        chk("bp_A_imm", {32'h0, b32.out_imm}, 64'h1);
        chk("bp_ready_one", {63'h0, b32.in_ready}, 64'h1);
        b32.in_instr = 32'h00200093;
        tick();
        chk("bp_ready_full", {63'h0, b32.in_ready}, 64'h0);
        chk("bp_A_stable1", {32'h0, b32.out_imm}, 64'h1);
        b32.in_instr = 32'h00300093;
        tick();
        chk("bp_ready_full2", {63'h0, b32.in_ready}, 64'h0);
        chk("bp_A_stable2", {32'h0, b32.out_imm}, 64'h1);
        chk("bp_A_instr", {32'h0, b32.out_instr}, 64'h00100093);
        b32.out_ready = 1'b1;
        tick();
        chk("bp_B_imm", {32'h0, b32.out_imm}, 64'h2);
        chk("bp_ready_after_pop", {63'h0, b32.in_ready}, 64'h1);
        tick();
        chk("bp_C_imm", {32'h0, b32.out_imm}, 64'h3);
        b32.in_instr = 32'h00400093;
        tick();
        chk("bp_D_imm", {32'h0, b32.out_imm}, 64'h4);
        chk("bp_D_valid", {63'h0, b32.out_valid}, 64'h1);
        b32.in_valid = 1'b0;
        tick();
        chk("bp_empty", {63'h0, b32.out_valid}, 64'h0);

        // Dual lane: lane0 jal -4, lane1 srai 5
        b2.in_valid = 1'b1;
        b2.in_instr = {32'h4050D093, 32'hFFDFF0EF};
        tick();
        b2.in_valid = 1'b0;
        chk("l2_valid", {63'h0, b2.out_valid}, 64'h1);
        chk("l2_imm", b2.out_imm, {32'h00000005, 32'hFFFFFFFC});
        chk("l2_fmt", {58'h0, b2.out_fmt}, {58'h0, 3'd6, 3'd5});
        chk("l2_ill", {62'h0, b2.out_illegal}, 64'h0);

        // RV64
        b64.in_valid = 1'b1;
        b64.in_instr = 32'hFFDFF0EF;
        tick();
        chk("x64_jal_imm", b64.out_imm, 64'hFFFFFFFFFFFFFFFC);
        chk("x64_jal_fmt", {61'h0, b64.out_fmt}, 64'd5);
        b64.in_instr = 32'h02109093;
        tick();
        chk("x64_slli_imm", b64.out_imm, 64'd33);
        chk("x64_slli_fmt", {61'h0, b64.out_fmt}, 64'd6);
        b64.in_instr = 32'h0000001B;
        tick();
        chk("x64_opimm32_ill", {63'h0, b64.out_illegal}, 64'h0);
        chk("x64_opimm32_fmt", {61'h0, b64.out_fmt}, 64'd1);
        b64.in_instr = 32'h0210909B;
        tick();
        chk("x64_slliw_imm", b64.out_imm, 64'd1);
        b64.in_instr = 32'h0000003B;
        tick();
        chk("x64_op32_ill", {63'h0, b64.out_illegal}, 64'h0);
        chk("x64_op32_fmt", {61'h0, b64.out_fmt}, 64'd0);
        b64.in_valid = 1'b0;
        tick();

        // Reset while FULL
        b32.out_ready = 1'b0;
        b32.in_valid  = 1'b1;
        b32.in_instr  = 32'h00100093;
        tick();
        b32.in_instr  = 32'h00200093;
        tick();
        chk("rf_full", {63'h0, b32.in_ready}, 64'h0);
        reset = 1'b1;
        b32.in_instr = 32'h00300093;
        tick();
        chk("rf_valid", {63'h0, b32.out_valid}, 64'h0);
        chk("rf_imm", {32'h0, b32.out_imm}, 64'h0);
        chk("rf_fmt", {61'h0, b32.out_fmt}, 64'h0);
        chk("rf_ill", {63'h0, b32.out_illegal}, 64'h0);
        chk("rf_instr", {32'h0, b32.out_instr}, 64'h0);
        chk("rf_in_ready", {63'h0, b32.in_ready}, 64'h0);
        tick();
        chk("rf_ignore_valid", {63'h0, b32.out_valid}, 64'h0);
        reset = 1'b0;
        b32.out_ready = 1'b1;
        b32.in_instr  = 32'h123450B7;
        #1;
        chk("rf_release_ready", {63'h0, b32.in_ready}, 64'h1);
        tick();
        chk("rf_new_valid", {63'h0, b32.out_valid}, 64'h1);
        chk("rf_new_imm", {32'h0, b32.out_imm}, 64'h12345000);
        b32.in_valid = 1'b0;
        tick();
        chk("rf_new_drain", {63'h0, b32.out_valid}, 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/imm_gen_stage.md
Name: imm_gen_stage

Overview:
Registered, multi-lane immediate-generation stage for the pipelined core. It accepts LANES instructions per beat over a valid/ready handshake and decodes each lane's immediate, format class and legality. Results are held in a 2-entry skid buffer, so in_ready is a registered signal and full throughput is sustained under backpressure. It sits between fetch/IF-ID and the register-read/execute stage, and is generalised in XLEN and lane count.

Parameters:
XLEN, 32, immediate output width; legal values 32 or 64; all immediates are sign-extended to XLEN.
LANES, 1, number of instructions per beat; legal values 1..4.
SKID, 1, 1 = 2-entry skid buffer; 0 = single output register with in_ready = out_ready | ~out_valid (combinational path).

Ports:
clk  in  1  core clock; all state updates on rising edge.
reset  in  1  synchronous, active-high reset.
in_valid  in  1  beat on in_instr is valid.
in_ready  out  1  stage can accept a beat this cycle.
in_instr  in  32*LANES  lane i is at bits [32*i+31:32*i].
out_valid  out  1  out_* holds a valid beat.
out_ready  in  1  consumer accepts the beat this cycle.
out_imm  out  XLEN*LANES  immediate per lane.
out_fmt  out  3*LANES  format code per lane (imm_fmt_e).
out_illegal  out  LANES  per lane: opcode not in the supported set.
out_instr  out  32*LANES  registered copy of the instruction per lane.

Behaviour:
- Decode (combinational, per lane, on opcode bits [6:0]):
  - LUI/AUIPC: fmt U; imm = sext({ins[31:12],12'b0}).
  - JAL: fmt J; imm = sext({ins[31],ins[19:12],ins[20],ins[30:21],1'b0}). The sign bit is ins[31].
  - BRANCH: fmt B; imm = sext({ins[31],ins[7],ins[30:25],ins[11:8],1'b0}).
  - STORE: fmt S; imm = sext({ins[31:25],ins[11:7]}).
  - JALR/LOAD: fmt I; imm = sext(ins[31:20]).
  - OP-IMM:
    - funct3 001/101: fmt SH; imm = zext of shamt. XLEN=32 uses ins[24:20]; XLEN=64 uses ins[25:20].
    - otherwise: fmt I; imm = sext(ins[31:20]).
  - OP (R-type): fmt R; imm = 0.
  - Any other opcode: fmt NONE, imm = 0, illegal = 1.
  - For XLEN=64, OP-IMM-32 (0011011) and OP-32 (0111011) are also legal. OP-IMM-32 shamt is ins[24:20].
- Latency: exactly 1 cycle from accepted input (in_valid & in_ready) to out_valid.
- Skid FSM (SKID=1), states:
  - EMPTY: out_valid=0, in_ready=1.
  - ONE: out_valid=1, in_ready=1.
  - FULL: out_valid=1, in_ready=0; the skid register holds the second beat.
- Transitions (push = in_valid & in_ready, pop = out_valid & out_ready):
  - EMPTY + push → ONE.
  - ONE: push & ~pop → FULL; pop & ~push → EMPTY; push & pop → ONE, with the main register loaded with the new beat.
  - FULL + pop → ONE, with the skid beat moved to the main register.
  - FULL: no push is possible (in_ready=0).
- Ordering: beats leave strictly in arrival order; no beat is dropped or duplicated.
- out_* stays stable while out_valid & ~out_ready.
- in_ready depends only on state, never on out_ready (SKID=1).
- All lanes of a beat move together; there is no per-lane valid.
- Reset: state EMPTY; out_valid=0; out_imm, out_fmt, out_illegal, out_instr = 0; in_ready=0 during reset, 1 on the first cycle after reset deasserts.
  - Reset mid-operation discards both buffered beats.
  - in_valid is ignored while reset is high.

Decomposition:
- Package imm_pkg:
  - opcode localparams: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP, OP_IMM_32, OP_32.
  - typedef enum logic[2:0] imm_fmt_e: R=0, I=1, S=2, B=3, U=4, J=5, SH=6, NONE=7.
  - state enum skid_state_e: EMPTY, ONE, FULL.
- Sub-module imm_decode_lane: combinational, parameter XLEN; inputs instr; outputs imm, fmt, illegal. It is instantiated LANES times via generate.
- The top level holds only the skid FSM and the registers.

Test Plan:
- XLEN=32, LANES=1, out_ready=1. Drive 0xFFDFF0EF (jal x1,-4) → next cycle out_imm=0xFFFFFFFC, fmt J. Drive 0xFE000CE3 (beq -8) → 0xFFFFFFF8, fmt B.
- Drive 0xFE21AE23 (sw -4) → imm 0xFFFFFFFC, fmt S. Drive 0x123450B7 (lui) → imm 0x12345000, fmt U. Drive 0x4050D093 (srai 5) → imm 0x00000005, fmt SH. Drive 0x0000007F → illegal=1, imm 0, fmt NONE.
- LANES=2: in_instr={0x4050D093,0xFFDFF0EF} → lane0 imm 0xFFFFFFFC fmt J; lane1 imm 5 fmt SH; both in the same beat.
- Backpressure: stream 4 beats A..D with out_ready=0 → in_ready drops after B is accepted, out shows A stable. Raise out_ready → A, B, C, D emerge in order, one per cycle, none lost.
- XLEN=64: drive 0xFFDFF0EF → imm 0xFFFFFFFFFFFFFFFC. Drive slli shamt 33 (0x02109093) → imm 33. Drive opcode 0011011 → illegal=0.
- Assert reset while in state FULL → next cycle out_valid=0, all outputs 0. After release, in_ready=1 and a new beat passes with 1-cycle latency.
